fetch_controller: RTL and testbench

- Sequences the 16-bit, 1024-word instruction memory.
- Owns the program counter and drives the memory address. Reads back the combinational instruction word in the same cycle.
- Buffers fetched words with their PCs in a small prefetch queue, presented to decode through a valid/ready handshake.
- Handles branch redirects with a queue flush, halting, and out-of-range fetch faults.

---
 rtl/fetch_controller.sv | 140 ++++++++++++++
 tb/tb_fetch_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, reads a combinational
// instruction memory and buffers {instruction, PC} pairs in a small prefetch
// queue that decode drains through a valid/ready handshake.
module fetch_controller #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    MEM_DEPTH   = 1024,
    parameter int                    QUEUE_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic                  Halt,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectAddr,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    input  logic [DATA_WIDTH-1:0] MemInstruction,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic [ADDR_WIDTH-1:0] InstrPC,
    output logic                  FetchFault,
    output logic                  Busy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    // One extra bit so a MEM_DEPTH equal to 2^ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   MEM_LIMIT  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FAULT
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic                    fault_q, fault_d;

    logic [DATA_WIDTH-1:0]   instr_buf_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_buf_q    [QUEUE_DEPTH];

    logic                    pop;
    logic                    push;
    logic                    pc_in_range;
    logic                    fault_hit;

    // Handshake, push and fault qualification for the current cycle.
    always_comb begin
        pc_in_range = ({1'b0, pc_q} < MEM_LIMIT);
        pop         = (count_q != '0) && InstrReady;
        push        = (state_q == S_FETCH) && !Halt && !Redirect && pc_in_range &&
                      ((count_q < FULL_COUNT) || pop);
        fault_hit   = (state_q == S_FETCH) && !Halt && !Redirect && !pc_in_range;
    end

    // Next-state logic for FSM, PC, queue pointers and fault flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fault_d = fault_q;

        if (Redirect) begin
            // A head consumed this cycle is simply discarded with the flush.
            state_d = S_FETCH;
            pc_d    = RedirectAddr;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            fault_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE:  if (Start) state_d = S_FETCH;
                S_FETCH: if (fault_hit) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase

            if (push) begin
                pc_d   = pc_q + ADDR_WIDTH'(1);
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fault_q <= fault_d;
        end
    end

    // Queue storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            instr_buf_q[tail_q] <= MemInstruction;
            pc_buf_q[tail_q]    <= pc_q;
        end
    end

    assign MemAddress  = pc_q;
    assign InstrValid  = (count_q != '0);
    assign Instruction = InstrValid ? instr_buf_q[head_q] : '0;
    assign InstrPC     = InstrValid ? pc_buf_q[head_q] : '0;
    assign FetchFault  = fault_q;
    assign Busy        = (state_q == S_FETCH);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a combinational memory model
// holding mem[i] = 16'h1000 + i.
module tb_fetch_controller;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Halt;
    logic        Redirect;
    logic [15:0] RedirectAddr;
    logic [15:0] MemAddress;
    logic [15:0] MemInstruction;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] Instruction;
    logic [15:0] InstrPC;
    logic        FetchFault;
    logic        Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_controller #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .MEM_DEPTH   (1024),
        .QUEUE_DEPTH (2),
        .RESET_PC    (16'h0000)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Start          (Start),
        .Halt           (Halt),
        .Redirect       (Redirect),
        .RedirectAddr   (RedirectAddr),
        .MemAddress     (MemAddress),
        .MemInstruction (MemInstruction),
        .InstrValid     (InstrValid),
        .InstrReady     (InstrReady),
        .Instruction    (Instruction),
        .InstrPC        (InstrPC),
        .FetchFault     (FetchFault),
        .Busy           (Busy)
    );

    assign MemInstruction = 16'h1000 + MemAddress;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc);
        chk({tag, ".valid"}, 32'(InstrValid), 32'd1);
        chk({tag, ".pc"},    32'(InstrPC),    32'(pc));
        chk({tag, ".instr"}, 32'(Instruction), 32'(16'h1000 + pc));
    endtask

    initial begin
        Reset_n      = 1'b0;
        Start        = 1'b0;
        Halt         = 1'b0;
        Redirect     = 1'b0;
        RedirectAddr = '0;
        InstrReady   = 1'b0;
        #2;
        chk("rst.valid", 32'(InstrValid),  32'd0);
        chk("rst.instr", 32'(Instruction), 32'd0);
        chk("rst.pc",    32'(InstrPC),     32'd0);
        chk("rst.fault", 32'(FetchFault),  32'd0);
        chk("rst.busy",  32'(Busy),        32'd0);
        chk("rst.addr",  32'(MemAddress),  32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        chk("idle.busy", 32'(Busy), 32'd0);

        // Streaming with decode always ready
        Start      = 1'b1;
        InstrReady = 1'b1;
        tick();
        Start = 1'b0;
        chk("s1.busy",  32'(Busy),       32'd1);
        chk("s1.valid", 32'(InstrValid), 32'd0);
        chk("s1.addr",  32'(MemAddress), 32'd0);
        tick();
        chk_head("s1.h0", 16'd0);
        chk("s1.addr1", 32'(MemAddress), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_head("s1.hn", 16'(i));
        end
        chk("s1.addr5", 32'(MemAddress), 32'd5);

        // Redirect at PC 5 to 0x200
        Redirect     = 1'b1;
        RedirectAddr = 16'h0200;
        tick();
        Redirect = 1'b0;
        chk("rd.bubble", 32'(InstrValid), 32'd0);
        chk("rd.addr",   32'(MemAddress), 32'h200);
        chk("rd.busy",   32'(Busy),       32'd1);
        tick();
        chk_head("rd.h200", 16'h0200);
        tick();
        chk_head("rd.h201", 16'h0201);

        // Run off the end of memory
        Redirect     = 1'b1;
        RedirectAddr = 16'h03FE;
        tick();
        Redirect = 1'b0;
        chk("ft.bubble", 32'(InstrValid), 32'd0);
        tick();
        chk_head("ft.h3fe", 16'h03FE);
        chk("ft.nofault", 32'(FetchFault), 32'd0);
        tick();
        chk_head("ft.h3ff", 16'h03FF);
        chk("ft.addr400", 32'(MemAddress), 32'h400);
        tick();
        chk("ft.fault", 32'(FetchFault), 32'd1);
        chk("ft.valid", 32'(InstrValid), 32'd0);
        chk("ft.busy",  32'(Busy),       32'd0);
        chk("ft.hold",  32'(MemAddress), 32'h400);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("ft.sticky", 32'(FetchFault), 32'd1);
        chk("ft.nostart", 32'(Busy),      32'd0);
        Redirect     = 1'b1;
        RedirectAddr = 16'h0010;
        tick();
        Redirect = 1'b0;
        chk("ft.clear", 32'(FetchFault), 32'd0);
        chk("ft.busy2", 32'(Busy),       32'd1);
        chk("ft.addr10", 32'(MemAddress), 32'h10);
        tick();
        chk_head("ft.h10", 16'h0010);

        // Fill the queue, then reset asynchronously mid-cycle
        InstrReady = 1'b0;
        tick();
        tick();
        chk_head("ar.full", 16'h0010);
        chk("ar.addr", 32'(MemAddress), 32'h12);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("ar.valid", 32'(InstrValid),  32'd0);
        chk("ar.instr", 32'(Instruction), 32'd0);
        chk("ar.fault", 32'(FetchFault),  32'd0);
        chk("ar.busy",  32'(Busy),        32'd0);
        chk("ar.addr0", 32'(MemAddress),  32'd0);
        #2;
        Reset_n = 1'b1;
        tick();
        chk("ar.idle",  32'(Busy),       32'd0);
        chk("ar.novld", 32'(InstrValid), 32'd0);

        // Back-pressure: queue fills and holds
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk_head("bp.h0", 16'd0);
        chk("bp.addr2", 32'(MemAddress), 32'd2);
        tick();
        chk_head("bp.stable", 16'd0);
        chk("bp.addr2b", 32'(MemAddress), 32'd2);
        InstrReady = 1'b1;
        tick();
        chk_head("bp.h1", 16'd1);
        tick();
        chk_head("bp.h2", 16'd2);

        // Halt for four edges while the queue drains; Start is ignored
        Halt  = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk_head("hl.h3", 16'd3);
        chk("hl.addr4", 32'(MemAddress), 32'd4);
        tick();
        chk("hl.empty", 32'(InstrValid), 32'd0);
        tick();
        tick();
        chk("hl.empty2", 32'(InstrValid), 32'd0);
        chk("hl.hold",   32'(MemAddress), 32'd4);
        Halt = 1'b0;
        tick();
        chk_head("hl.h4", 16'd4);
        tick();
        chk_head("hl.h5", 16'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
